// File: rtl/half_adder_pkg.sv
// Shared constants and result type for the registered half adder.
// The result struct is the default-width view; wider instances build the same layout locally.
package half_adder_pkg;

   localparam int HA_WIDTH = 1;

   typedef struct packed {
      logic [HA_WIDTH-1:0] sum;
      logic [HA_WIDTH-1:0] carry;
   } ha_result_t;

endpackage

// File: rtl/ha_cell.sv
// Purely combinational bitwise half adder: every bit position is independent, no ripple.
module ha_cell
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_WIDTH
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic [WIDTH-1:0] o_sum,
   output logic [WIDTH-1:0] o_carry
);

   assign o_sum   = i_a ^ i_b;
   assign o_carry = i_a & i_b;

endmodule

// File: rtl/half_adder_reg.sv
// Registered, valid/ready half adder with a main result register plus a skid register.
// in_ready is taken from the skid occupancy only, so there is no ready path from sink to source.
module half_adder_reg
   import half_adder_pkg::*;
#(
   parameter int WIDTH = HA_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] sum,
   output logic [WIDTH-1:0] carry,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic [WIDTH-1:0] carry;
   } res_t;

   logic [WIDTH-1:0] w_sum;
   logic [WIDTH-1:0] w_carry;
   res_t             w_new;
   res_t             r_main;
   res_t             r_skid;
   res_t             w_main_nxt;
   res_t             w_skid_nxt;
   logic             r_main_vld;
   logic             r_skid_vld;
   logic             w_main_vld_nxt;
   logic             w_skid_vld_nxt;
   logic             w_acc;
   logic             w_drain;

   ha_cell #(.WIDTH(WIDTH)) u_cell (
      .i_a     (in0),
      .i_b     (in1),
      .o_sum   (w_sum),
      .o_carry (w_carry)
   );

   assign w_new     = {w_sum, w_carry};
   assign in_ready  = !r_skid_vld;
   assign out_valid = r_main_vld;
   assign sum       = r_main.sum;
   assign carry     = r_main.carry;
   assign w_acc     = in_valid && !r_skid_vld;
   assign w_drain   = r_main_vld && out_ready;

   always_comb begin
      w_main_nxt     = r_main;
      w_skid_nxt     = r_skid;
      w_main_vld_nxt = r_main_vld;
      w_skid_vld_nxt = r_skid_vld;
      if (r_skid_vld) begin
         // Full: nothing can be accepted, a drain promotes the skid entry.
         if (w_drain) begin
            w_main_nxt     = r_skid;
            w_skid_nxt     = '0;
            w_skid_vld_nxt = 1'b0;
         end
      end else if (r_main_vld) begin
         if (w_acc && w_drain) begin
            w_main_nxt = w_new;
         end else if (w_acc) begin
            w_skid_nxt     = w_new;
            w_skid_vld_nxt = 1'b1;
         end else if (w_drain) begin
            w_main_vld_nxt = 1'b0;
         end
      end else if (w_acc) begin
         w_main_nxt     = w_new;
         w_main_vld_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main     <= '0;
         r_skid     <= '0;
         r_main_vld <= 1'b0;
         r_skid_vld <= 1'b0;
      end else begin
         r_main     <= w_main_nxt;
         r_skid     <= w_skid_nxt;
         r_main_vld <= w_main_vld_nxt;
         r_skid_vld <= w_skid_vld_nxt;
      end
   end

endmodule

// File: tb/tb_half_adder_reg.sv
// Directed bench for half_adder_reg: a 1-bit and an 8-bit instance checked against a queue scoreboard.
module tb_half_adder_reg;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       a_in0, a_in1, a_in_valid, a_in_ready, a_sum, a_carry, a_out_valid, a_out_ready;
   logic [7:0] b_in0, b_in1, b_sum, b_carry;
   logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;

   logic [1:0]  q1[$];
   logic [15:0] q8[$];
   int          n_assert = 0;
   int          n_fail = 0;

   always #10 clk = ~clk;

   half_adder_reg #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in0(a_in0), .in1(a_in1), .in_valid(a_in_valid),
      .in_ready(a_in_ready), .sum(a_sum), .carry(a_carry), .out_valid(a_out_valid),
      .out_ready(a_out_ready)
   );

   half_adder_reg #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .in0(b_in0), .in1(b_in1), .in_valid(b_in_valid),
      .in_ready(b_in_ready), .sum(b_sum), .carry(b_carry), .out_valid(b_out_valid),
      .out_ready(b_out_ready)
   );

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called one time unit after an edge: settles both handshakes for the coming edge.
   task automatic tick();
      logic [1:0]  e1;
      logic [15:0] e8;
      if (a_out_valid && a_out_ready) begin
         if (q1.size() == 0) check("sb1_unexpected", {15'd0, a_out_valid}, 16'd0);
         else begin
            e1 = q1.pop_front();
            check("sb1_result", {14'd0, a_sum, a_carry}, {14'd0, e1});
         end
      end
      if (b_out_valid && b_out_ready) begin
         if (q8.size() == 0) check("sb8_unexpected", {15'd0, b_out_valid}, 16'd0);
         else begin
            e8 = q8.pop_front();
            check("sb8_result", {b_sum, b_carry}, e8);
         end
      end
      if (a_in_valid && a_in_ready) q1.push_back({a_in0 ^ a_in1, a_in0 & a_in1});
      if (b_in_valid && b_in_ready) q8.push_back({b_in0 ^ b_in1, b_in0 & b_in1});
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0] tt_in[6];
      logic [1:0] tt_exp[6];
      tt_in  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b00};
      tt_exp = '{2'b00, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
      {a_in0, a_in1, a_in_valid} = '0;
      a_out_ready = 1'b1;
      {b_in0, b_in1} = '0;
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;

      // Reset state
      #5;
      check("rst_out8", {b_sum, b_carry}, 16'h0000);
      check("rst_flags8", {14'd0, b_out_valid, b_in_ready}, 16'd1);
      check("rst_flags1", {12'd0, a_sum, a_carry, a_out_valid, a_in_ready}, 16'd1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Truth table on the 1-bit instance, back to back
      for (int i = 0; i < 6; i++) begin
         {a_in0, a_in1} = tt_in[i];
         a_in_valid = 1'b1;
         tick();
         check("tt_latency_valid", {15'd0, a_out_valid}, 16'd1);
         check("tt_const", {14'd0, a_sum, a_carry}, {14'd0, tt_exp[i]});
      end
      a_in_valid = 1'b0;
      tick();
      check("tt_drained", {15'd0, a_out_valid}, 16'd0);

      // Vector width, independent bits
      b_in0 = 8'hF0; b_in1 = 8'h3C; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      check("vec_result", {b_sum, b_carry}, 16'hCC30);
      check("vec_valid", {15'd0, b_out_valid}, 16'd1);
      tick();

      // Backpressure: only two of three pairs are taken
      b_out_ready = 1'b0;
      b_in0 = 8'h11; b_in1 = 8'h01; b_in_valid = 1'b1;
      tick();
      check("bp_ready_after1", {15'd0, b_in_ready}, 16'd1);
      b_in0 = 8'h22; b_in1 = 8'h66;
      tick();
      check("bp_ready_full", {15'd0, b_in_ready}, 16'd0);
      b_in0 = 8'h33; b_in1 = 8'hFF;
      tick();
      check("bp_ready_held", {15'd0, b_in_ready}, 16'd0);
      check("bp_accepted", 16'(q8.size()), 16'd2);
      check("bp_head", {b_sum, b_carry}, 16'h1001);
      b_in_valid = 1'b0;
      b_out_ready = 1'b1;
      tick();
      check("bp_ready_back", {15'd0, b_in_ready}, 16'd1);
      check("bp_second", {b_sum, b_carry}, 16'h4422);
      tick();
      check("bp_empty", {15'd0, b_out_valid}, 16'd0);

      // Stability under a five-cycle stall
      b_out_ready = 1'b0;
      b_in0 = 8'h5A; b_in1 = 8'hFF; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("stall_data", {b_sum, b_carry}, 16'hA55A);
         check("stall_valid", {15'd0, b_out_valid}, 16'd1);
         tick();
      end
      b_out_ready = 1'b1;
      tick();

      // Streaming: accept and drain every cycle
      b_out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         b_in0 = 8'($urandom); b_in1 = 8'($urandom); b_in_valid = 1'b1;
         tick();
         check("stream_ready", {15'd0, b_in_ready}, 16'd1);
         check("stream_valid", {15'd0, b_out_valid}, 16'd1);
      end
      b_in_valid = 1'b0;
      tick();
      check("stream_done", 16'(q8.size()), 16'd0);

      // Reset between edges with two entries buffered
      b_out_ready = 1'b0;
      b_in0 = 8'hAA; b_in1 = 8'h0F; b_in_valid = 1'b1;
      tick();
      b_in0 = 8'h0C; b_in1 = 8'h0A;
      tick();
      b_in_valid = 1'b0;
      check("mid_full", {15'd0, b_in_ready}, 16'd0);
      #5;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out", {b_sum, b_carry}, 16'h0000);
      check("mid_rst_flags", {14'd0, b_out_valid, b_in_ready}, 16'd1);
      q8.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      check("post_rst_ready", {15'd0, b_in_ready}, 16'd1);
      b_out_ready = 1'b1;
      b_in0 = 8'h81; b_in1 = 8'h83; b_in_valid = 1'b1;
      tick();
      b_in_valid = 1'b0;
      check("post_rst_result", {b_sum, b_carry}, 16'h0281);
      tick();

      check("q1_left", 16'(q1.size()), 16'd0);
      check("q8_left", 16'(q8.size()), 16'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
